div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: 8-bit unsigned sequential restoring divider.
//
// One quotient bit is produced per clock, MSB first, so a nonzero division
// spends 8 cycles in CALC and then one cycle in DONE. A zero divisor skips
// CALC entirely and reports quotient 8'hFF, remainder = dividend.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request pulse, accepted in IDLE or DONE, ignored in CALC
//   dividend  in   8-bit unsigned dividend, sampled with start
//   divisor   in   8-bit unsigned divisor, sampled with start
//   quotient  out  registered quotient, held until the next accepted start
//   remainder out  registered remainder, held until the next accepted start
//   busy      out  high while in CALC
//   done      out  one-cycle pulse in DONE; results valid
//   div_zero  out  last accepted divisor was zero; held with results
module div_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [7:0] dvd_q,   dvd_d;   // dividend bits still to consume; quotient bits shift in at the bottom
  logic [7:0] dvs_q,   dvs_d;
  logic [8:0] prem_q,  prem_d;  // 9-bit partial remainder
  logic [7:0] quo_q,   quo_d;
  logic [7:0] rem_q,   rem_d;
  logic       dz_q,    dz_d;

  // Restoring step. The trial is done one bit wider than the shifted
  // partial remainder so its top bit is a clean borrow flag.
  logic [9:0] shifted;
  logic [9:0] trial;
  logic       step_ok;
  logic [8:0] prem_next;
  logic [7:0] quo_next;

  always_comb begin
    shifted   = {prem_q, dvd_q[7]};
    trial     = shifted - {2'b00, dvs_q};
    step_ok   = ~trial[9];
    prem_next = step_ok ? trial[8:0] : shifted[8:0];
    quo_next  = {dvd_q[6:0], step_ok};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          dz_d   = 1'b0;
          cnt_d  = '0;
          prem_d = '0;
          if (divisor == 8'd0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        prem_d = prem_next;
        dvd_d  = quo_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quo_d   = quo_next;
          rem_d   = prem_next[7:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);

endmodule
